// File: rtl/muldiv_issue_ctrl.sv
// Issue controller for the M-extension MULDIV unit. It holds one request's operands,
// pulses start, polls busy until the unit finishes, then hands the result to write-back.
module muldiv_issue_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int RD_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rstLow,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_funct3_i,
  input  logic [DATA_WIDTH-1:0] req_rs1_i,
  input  logic [DATA_WIDTH-1:0] req_rs2_i,
  input  logic [RD_WIDTH-1:0]   req_rd_i,
  output logic [DATA_WIDTH-1:0] md_rs1_o,
  output logic [DATA_WIDTH-1:0] md_rs2_o,
  output logic [2:0]            md_funct3_o,
  output logic                  md_start_o,
  input  logic                  md_busy_i,
  input  logic [DATA_WIDTH-1:0] md_c_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [RD_WIDTH-1:0]   wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [DATA_WIDTH-1:0] r_md_rs1;
  logic [DATA_WIDTH-1:0] r_md_rs2;
  logic [2:0]            r_md_funct3;
  logic [RD_WIDTH-1:0]   r_rd;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_err;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;

  // An idle controller has nothing to abort, so a flush alongside a request is ignored.
  assign w_accept  = (r_state == S_IDLE) & req_valid_i & ~md_busy_i;
  assign w_cnt_inc = (r_cnt == CNT_W'(TIMEOUT_CYCLES)) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_done    = (r_state == S_WAIT) & ~md_busy_i & ~flush_i;
  assign w_timeout = (r_state == S_WAIT) & md_busy_i & ~flush_i
                   & (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_START;
      S_START: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (!md_busy_i)     w_state_nxt = (r_rd != '0) ? S_WB : S_IDLE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_WB:    if (wb_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i && (r_state != S_IDLE)) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstLow) begin
    if (!rstLow) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_md_rs1    <= '0;
      r_md_rs2    <= '0;
      r_md_funct3 <= '0;
      r_rd        <= '0;
      r_result    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_timeout;
      // Operands change only on acceptance; MULDIV's remainder reuse relies on them staying put.
      if (w_accept) begin
        r_md_rs1    <= req_rs1_i;
        r_md_rs2    <= req_rs2_i;
        r_md_funct3 <= req_funct3_i;
        r_rd        <= req_rd_i;
      end
      if (r_state == S_START) r_cnt <= '0;
      else if ((r_state == S_WAIT) && md_busy_i) r_cnt <= w_cnt_inc;
      if (w_done) r_result <= md_c_i;
    end
  end

  assign req_ready_o = (r_state == S_IDLE) & ~md_busy_i;
  assign md_rs1_o    = r_md_rs1;
  assign md_rs2_o    = r_md_rs2;
  assign md_funct3_o = r_md_funct3;
  assign md_start_o  = (r_state == S_START) & ~flush_i;
  assign wb_valid_o  = (r_state == S_WB) & ~flush_i;
  assign wb_rd_o     = r_rd;
  assign wb_data_o   = r_result;
  assign stall_o     = (r_state != S_IDLE);
  assign err_o       = r_err;

endmodule
